// File: rtl/lcrc_checker.sv
// Link CRC checker: strips the trailing 2-word LCRC from each packet, forwards
// the data words, and reports the CRC check result one cycle after the last word.

module lcrc_fold (
  input  logic [31:0] crc,
  input  logic [15:0] word,
  output logic [31:0] nxt
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // Bit index order equals wire order: low byte first, bit 0 first.
  always_comb begin
    nxt = crc;
    for (int i = 0; i < 16; i++)
      nxt = {nxt[30:0], 1'b0} ^ ((nxt[31] ^ word[i]) ? POLY : 32'h0);
  end
endmodule

module lcrc_checker #(
  parameter logic [31:0] SEED  = 32'h04C11DB7,
  parameter int          ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [15:0]      in,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [15:0]      out,
  output logic             chk_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [31:0]      crc_calc,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, FILL0, FILL1, STREAM} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [15:0] h0, h1;
  logic        first;

  logic [31:0] crc_nxt, mapped;
  logic        abort, runt, fin, push, good, fail;

  lcrc_fold u_fold (.crc(crc), .word(h0), .nxt(crc_nxt));

  always_comb begin
    mapped = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        mapped[8*b+i] = crc_nxt[8*b+7-i];
  end

  // Two lookahead words stay buffered so the LCRC never reaches the output.
  assign abort = in_valid & in_sop & (state != IDLE);
  assign runt  = in_valid & in_eop & (in_sop | (state == FILL0) | (state == FILL1));
  assign push  = in_valid & ~in_sop & (state == STREAM);
  assign fin   = push & in_eop;
  assign good  = fin & ({in, h1} == mapped);
  assign fail  = abort | runt | (fin & ~good);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      crc       <= SEED;
      h0        <= '0;
      h1        <= '0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out       <= '0;
      chk_done  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      crc_calc  <= '0;
      err_count <= '0;
    end else begin
      out_valid <= push;
      out_sop   <= push & first;
      out_eop   <= fin;
      chk_done  <= abort | runt | fin;
      crc_ok    <= good;
      crc_err   <= fail;
      if (push) out <= h0;
      if (fin) crc_calc <= mapped;
      if (fail && !(&err_count)) err_count <= err_count + 1'b1;

      if (in_valid) begin
        if (in_sop) begin
          crc   <= SEED;
          h0    <= in;
          first <= 1'b1;
          state <= in_eop ? IDLE : FILL1;
        end else begin
          case (state)
            IDLE: ;
            FILL0: begin
              h0    <= in;
              state <= in_eop ? IDLE : FILL1;
            end
            FILL1: begin
              h1    <= in;
              state <= in_eop ? IDLE : STREAM;
            end
            STREAM: begin
              crc   <= crc_nxt;
              h0    <= h1;
              h1    <= in;
              first <= 1'b0;
              if (in_eop) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lcrc_checker.sv
// Directed bench for lcrc_checker; CRC values below were worked out by hand.

module tb_lcrc_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sop, in_eop;
  logic [15:0] in;
  logic        out_valid, out_sop, out_eop;
  logic [15:0] out;
  logic        chk_done, crc_ok, crc_err;
  logic [31:0] crc_calc;
  logic [15:0] err_count;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  lcrc_checker dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in(in),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out(out),
    .chk_done(chk_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .crc_calc(crc_calc), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Drive one accepted word; returns #1 after the accepting edge.
  task automatic wr(input logic [15:0] w, input logic s, input logic e);
    @(negedge clk);
    in_valid = 1'b1; in_sop = s; in_eop = e; in = w;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w, input logic s, input logic e);
    check({tag, ".vld"}, out_valid, 1'b1);
    check({tag, ".out"}, out, w);
    check({tag, ".sop"}, out_sop, s);
    check({tag, ".eop"}, out_eop, e);
  endtask

  task automatic chk_res(input string tag, input logic ok);
    check({tag, ".done"}, chk_done, 1'b1);
    check({tag, ".ok"}, crc_ok, ok);
    check({tag, ".err"}, crc_err, !ok);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in = '0;
    #1;
    check("rst.vld", out_valid, 1'b0);
    check("rst.done", chk_done, 1'b0);
    check("rst.cnt", err_count, 16'h0);
    check("rst.calc", crc_calc, 32'h0);
    check("rst.busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Good packet: one data word 0x0000, LCRC 0x801B35E1
    wr(16'h0000, 1, 0);
    check("g.busy", busy, 1'b1);
    check("g.vld0", out_valid, 1'b0);
    wr(16'h35E1, 0, 0);
    check("g.vld1", out_valid, 1'b0);
    wr(16'h801B, 0, 1);
    chk_word("g", 16'h0000, 1, 1);
    chk_res("g", 1);
    check("g.calc", crc_calc, 32'h801B35E1);
    check("g.busy_end", busy, 1'b0);
    idle();
    check("g.done_clr", chk_done, 1'b0);
    check("g.vld_clr", out_valid, 1'b0);

    // Corrupted LCRC
    wr(16'h0000, 1, 0);
    wr(16'h35E1, 0, 0);
    wr(16'h801A, 0, 1);
    chk_word("bad", 16'h0000, 1, 1);
    chk_res("bad", 0);
    check("bad.cnt", err_count, 16'd1);
    check("bad.calc", crc_calc, 32'h801B35E1);
    idle();

    // Runt: sop and eop on one word
    wr(16'h1234, 1, 1);
    check("runt.vld", out_valid, 1'b0);
    chk_res("runt", 0);
    check("runt.cnt", err_count, 16'd2);
    check("runt.calc", crc_calc, 32'h801B35E1);
    idle();

    // Abort by new sop, then the good packet
    wr(16'h1111, 1, 0);
    wr(16'h2222, 0, 0);
    wr(16'h0000, 1, 0);
    check("ab.vld", out_valid, 1'b0);
    chk_res("ab", 0);
    check("ab.cnt", err_count, 16'd3);
    wr(16'h35E1, 0, 0);
    check("ab.vld1", out_valid, 1'b0);
    wr(16'h801B, 0, 1);
    chk_word("ab2", 16'h0000, 1, 1);
    chk_res("ab2", 1);

    // Back-to-back with gaps; second packet has two data words, LCRC 0x92B0E6B1
    wr(16'h0000, 1, 0);
    idle();
    wr(16'h35E1, 0, 0);
    idle();
    check("bb.hold", busy, 1'b1);
    wr(16'h801B, 0, 1);
    chk_word("bb1", 16'h0000, 1, 1);
    chk_res("bb1", 1);
    wr(16'h0000, 1, 0);
    check("bb2.done0", chk_done, 1'b0);
    wr(16'h0000, 0, 0);
    idle();
    wr(16'hE6B1, 0, 0);
    chk_word("bb2a", 16'h0000, 1, 0);
    check("bb2a.done", chk_done, 1'b0);
    idle();
    check("bb2.gap", out_valid, 1'b0);
    wr(16'h92B0, 0, 1);
    chk_word("bb2b", 16'h0000, 0, 1);
    chk_res("bb2", 1);
    check("bb2.calc", crc_calc, 32'h92B0E6B1);
    check("bb2.cnt", err_count, 16'd3);

    // Reset mid-STREAM
    wr(16'h0000, 1, 0);
    wr(16'h35E1, 0, 0);
    wr(16'hAAAA, 0, 0);
    check("mr.push", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mr.vld", out_valid, 1'b0);
    check("mr.cnt", err_count, 16'h0);
    check("mr.calc", crc_calc, 32'h0);
    check("mr.busy", busy, 1'b0);
    check("mr.out", out, 16'h0);
    @(negedge clk); reset = 1'b0;
    idle();
    check("mr.done", chk_done, 1'b0);
    wr(16'h0000, 1, 0);
    wr(16'h35E1, 0, 0);
    wr(16'h801B, 0, 1);
    chk_word("mr2", 16'h0000, 1, 1);
    chk_res("mr2", 1);
    check("mr2.calc", crc_calc, 32'h801B35E1);
    check("mr2.cnt", err_count, 16'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
